// File: rtl/div_pipe_16bit_if.sv
// Operand/result bundle for the pipelined divider.
// Handshake: valid-only. div_en_in marks div_a/div_b as meaningful in the
// cycle it is high; div_en_out marks div_q/div_r/div_zero likewise. There is
// no ready: the pipeline accepts one operation every cycle and never stalls.
interface div_pipe_16bit_if #(
    parameter int size = 8
);
    logic                div_en_in;
    logic [2*size-1:0]   div_a;
    logic [size-1:0]     div_b;
    logic                div_en_out;
    logic [2*size-1:0]   div_q;
    logic [size-1:0]     div_r;
    logic                div_zero;

    // Requester side: drives operands, observes results.
    modport master (
        output div_en_in, div_a, div_b,
        input  div_en_out, div_q, div_r, div_zero
    );

    // Divider side: consumes operands, produces results.
    modport slave (
        input  div_en_in, div_a, div_b,
        output div_en_out, div_q, div_r, div_zero
    );
endinterface

// File: rtl/div_pipe_16bit.sv
// Fully pipelined unsigned restoring divider: 2*size-bit dividend by size-bit
// divisor. One quotient bit is resolved per stage, so latency is fixed at
// 2*size iteration stages plus the input and output registers.
// Divide by zero needs no special path: every trial subtraction of 0 succeeds,
// giving an all-ones quotient and the low dividend bits as remainder.
module div_pipe_16bit #(
    parameter int size = 8
) (
    input  logic             clk,
    input  logic             rst,
    div_pipe_16bit_if.slave  bus
);
    localparam int N = 2 * size;

    // Per-stage pipeline state. Index 0 is the input capture register,
    // index i holds the result of iteration stage i.
    logic [N:0]        v_r;
    logic [N-1:0]      a_r  [0:N-1];
    logic [size-1:0]   b_r  [0:N];
    // Only the low size bits of the partial remainder are stored: the top
    // bit of the trial value is consumed by the compare inside its stage.
    logic [size-1:0]   pr_r [0:N];
    logic [N-1:0]      q_r  [0:N];

    logic [size:0]     t_c   [1:N];
    logic [size-1:0]   pr_nx [1:N];
    logic [N-1:0]      q_nx  [1:N];

    // Iteration datapath: shift in the next dividend bit, trial-subtract.
    always_comb begin
        for (int i = 1; i <= N; i++) begin
            t_c[i]   = {pr_r[i-1], a_r[i-1][N-i]};
            pr_nx[i] = t_c[i][size-1:0];
            q_nx[i]  = q_r[i-1];
            if (t_c[i] >= {1'b0, b_r[i-1]}) begin
                pr_nx[i]       = size'(t_c[i] - {1'b0, b_r[i-1]});
                q_nx[i][N-i]   = 1'b1;
            end
        end
    end

    // Pipeline registers: input capture, valid shift and stage results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= '0;
            for (int i = 0; i < N; i++) begin
                a_r[i] <= '0;
            end
            for (int i = 0; i <= N; i++) begin
                b_r[i]  <= '0;
                pr_r[i] <= '0;
                q_r[i]  <= '0;
            end
        end else begin
            // Idle cycles load zeros so bubble data never reaches the stages.
            v_r[0]  <= bus.div_en_in;
            a_r[0]  <= bus.div_en_in ? bus.div_a : '0;
            b_r[0]  <= bus.div_en_in ? bus.div_b : '0;
            pr_r[0] <= '0;
            q_r[0]  <= '0;
            for (int i = 1; i <= N; i++) begin
                v_r[i]  <= v_r[i-1];
                b_r[i]  <= b_r[i-1];
                pr_r[i] <= pr_nx[i];
                q_r[i]  <= q_nx[i];
            end
            // The dividend is last needed by stage N, which reads a_r[N-1].
            for (int i = 1; i < N; i++) begin
                a_r[i] <= a_r[i-1];
            end
        end
    end

    // Output register: present results only alongside a valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.div_en_out <= 1'b0;
            bus.div_q      <= '0;
            bus.div_r      <= '0;
            bus.div_zero   <= 1'b0;
        end else begin
            bus.div_en_out <= v_r[N];
            if (v_r[N]) begin
                bus.div_q    <= q_r[N];
                bus.div_r    <= pr_r[N];
                bus.div_zero <= (b_r[N] == '0);
            end else begin
                bus.div_q    <= '0;
                bus.div_r    <= '0;
                bus.div_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_pipe_16bit.sv
// Bench for div_pipe_16bit: a cycle-delayed arithmetic model (/ and %) is
// compared with the DUT on every falling edge, and directed operations carry
// hand-computed literal results checked against both DUT and model.
module tb_div_pipe_16bit;
    localparam int LAT = 17;

    typedef struct packed {
        logic        v;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } res_t;

    typedef struct {
        int   cyc;
        res_t res;
    } lit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    res_t exp_q[$];
    res_t cur_exp = '0;
    lit_t lit_q[$];

    div_pipe_16bit_if #(.size(8)) bus ();

    div_pipe_16bit #(.size(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle counter.
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each sampled input becomes the visible result LAT
    // edges later; reset empties everything in flight.
    always @(posedge clk or posedge rst) begin : model
        res_t e;
        if (rst) begin
            exp_q.delete();
            cur_exp = '0;
        end else begin
            e = '0;
            if (bus.div_en_in) begin
                e.v = 1'b1;
                if (bus.div_b == 8'h00) begin
                    e.q = 16'hFFFF;
                    e.r = bus.div_a[7:0];
                    e.z = 1'b1;
                end else begin
                    e.q = bus.div_a / {8'h00, bus.div_b};
                    e.r = 8'(bus.div_a % {8'h00, bus.div_b});
                end
            end
            exp_q.push_back(e);
            if (exp_q.size() > LAT) cur_exp = exp_q.pop_front();
            else cur_exp = '0;
        end
    end

    // Scoreboard: every-cycle model compare plus pinned literal results.
    always @(negedge clk) begin : compare
        res_t act;
        lit_t l;
        act = {bus.div_en_out, bus.div_q, bus.div_r, bus.div_zero};
        n_vec++;
        if (act !== cur_exp) begin
            n_err++;
            $display("FAIL cycle_%0d model: got en=%b q=%h r=%h z=%b want en=%b q=%h r=%h z=%b",
                     cyc, act.v, act.q, act.r, act.z, cur_exp.v, cur_exp.q, cur_exp.r, cur_exp.z);
        end
        if (lit_q.size() > 0 && lit_q[0].cyc == cyc) begin
            l = lit_q.pop_front();
            n_vec++;
            if (act !== l.res) begin
                n_err++;
                $display("FAIL lit_dut cycle_%0d: got en=%b q=%h r=%h z=%b want en=%b q=%h r=%h z=%b",
                         cyc, act.v, act.q, act.r, act.z, l.res.v, l.res.q, l.res.r, l.res.z);
            end
            n_vec++;
            if (cur_exp !== l.res) begin
                n_err++;
                $display("FAIL lit_model cycle_%0d: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                         cyc, cur_exp.q, cur_exp.r, cur_exp.z, l.res.q, l.res.r, l.res.z);
            end
        end
    end

    // Driver: apply one cycle of inputs, return just after the sampling edge.
    task automatic drive(input logic en, input logic [15:0] a, input logic [7:0] b);
        bus.div_en_in = en;
        bus.div_a     = a;
        bus.div_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 8'($urandom));
    endtask

    // Issue one operation whose result is also known by hand.
    task automatic issue_lit(input logic [15:0] a, input logic [7:0] b,
                             input logic [15:0] q, input logic [7:0] r, input logic z);
        lit_t l;
        drive(1'b1, a, b);
        l.cyc = cyc + LAT;
        l.res = {1'b1, q, r, z};
        lit_q.push_back(l);
    endtask

    initial begin
        logic [7:0] b;
        bus.div_en_in = 1'b0;
        bus.div_a     = '0;
        bus.div_b     = '0;
        #2;
        // Reset held with random inputs toggling.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'($urandom), 16'($urandom), 8'($urandom));
        rst = 1'b0;
        bubble(20);

        // Single operation followed by idle cycles.
        issue_lit(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0);
        bubble(20);

        // Corner values back to back.
        issue_lit(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
        issue_lit(16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0);
        issue_lit(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
        bubble(3);

        // Divide by zero bracketed by ordinary operations.
        issue_lit(16'h0100, 8'h10, 16'h0010, 8'h00, 1'b0);
        issue_lit(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
        issue_lit(16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0);
        bubble(20);

        // Random stream, roughly 70% valid, mixed divisor ranges.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'h00;
                1, 2:    b = 8'($urandom_range(1, 3));
                3:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            drive($urandom_range(0, 9) < 7, 16'($urandom), b);
        end
        bubble(LAT + 3);

        // Reset while ten operations are in flight.
        for (int i = 0; i < 10; i++) drive(1'b1, 16'($urandom), 8'($urandom_range(1, 255)));
        rst = 1'b1;
        bubble(2);
        rst = 1'b0;
        bubble(5);
        issue_lit(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0);
        bubble(LAT + 5);

        n_vec++;
        if (lit_q.size() != 0) begin
            n_err++;
            $display("FAIL lit_pending: got %0d unchecked, want 0", lit_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
